// File: rtl/timer_mmio.sv
// Memory-mapped prescaled 32-bit timer with compare, sticky MATCH/OVF flags and a level irq.
// Sits between the CPU data port and data RAM: decodes its window, gates RAM writes, muxes read data.
module timer_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int          PRESC_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [31:0] ram_rdata,
  output logic        ram_we,
  output logic [31:0] cpu_rdata,
  output logic        irq
);

  logic               sel;
  logic [2:0]         off;
  logic               wr_ctrl, wr_presc, wr_count, wr_compare, wr_status;
  logic               tick, hit, wrap;
  logic [31:0]        rd_val;
  logic               unused_addr_bits;

  logic [3:0]         ctrl_reg, ctrl_next;
  logic [PRESC_W-1:0] presc_reg, presc_next;
  logic [PRESC_W-1:0] pc_reg, pc_next;
  logic [31:0]        count_reg, count_next;
  logic [31:0]        compare_reg, compare_next;
  logic               match_reg, match_next;
  logic               ovf_reg, ovf_next;
  logic               irq_reg;

  assign sel              = (cpu_addr[31:5] == BASE_ADDR[31:5]);
  assign off              = cpu_addr[4:2];
  assign unused_addr_bits = ^cpu_addr[1:0];
  assign ram_we           = cpu_we & ~sel;

  assign wr_ctrl    = cpu_we & sel & (off == 3'd0);
  assign wr_presc   = cpu_we & sel & (off == 3'd1);
  assign wr_count   = cpu_we & sel & (off == 3'd2);
  assign wr_compare = cpu_we & sel & (off == 3'd3);
  assign wr_status  = cpu_we & sel & (off == 3'd4);

  assign tick = ctrl_reg[0] && (pc_reg == presc_reg);
  assign hit  = (count_reg == compare_reg);
  assign wrap = (count_reg == 32'hFFFF_FFFF);

  always_comb begin
    ctrl_next    = ctrl_reg;
    presc_next   = presc_reg;
    count_next   = count_reg;
    compare_next = compare_reg;
    pc_next      = '0;

    if (ctrl_reg[0] && !tick)
      pc_next = pc_reg + 1'b1;
    if (wr_presc)
      pc_next = '0;

    if (tick) begin
      if (wrap)
        count_next = '0;
      else if (hit && ctrl_reg[1])
        count_next = '0;
      else
        count_next = count_reg + 32'd1;
      if (hit && ctrl_reg[3])
        ctrl_next[0] = 1'b0;
    end

    // CPU writes take priority over hardware updates of the same register.
    if (wr_ctrl)    ctrl_next    = cpu_wdata[3:0];
    if (wr_presc)   presc_next   = cpu_wdata[PRESC_W-1:0];
    if (wr_count)   count_next   = cpu_wdata;
    if (wr_compare) compare_next = cpu_wdata;

    // Hardware set beats a W1C clear landing on the same edge.
    match_next = (match_reg & ~(wr_status & cpu_wdata[0])) | (tick & hit);
    ovf_next   = (ovf_reg   & ~(wr_status & cpu_wdata[1])) | (tick & wrap);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_reg    <= '0;
      presc_reg   <= '0;
      pc_reg      <= '0;
      count_reg   <= '0;
      compare_reg <= '0;
      match_reg   <= 1'b0;
      ovf_reg     <= 1'b0;
      irq_reg     <= 1'b0;
    end else begin
      ctrl_reg    <= ctrl_next;
      presc_reg   <= presc_next;
      pc_reg      <= pc_next;
      count_reg   <= count_next;
      compare_reg <= compare_next;
      match_reg   <= match_next;
      ovf_reg     <= ovf_next;
      irq_reg     <= ctrl_reg[2] & match_reg;
    end
  end

  assign irq = irq_reg;

  always_comb begin
    rd_val = '0;
    case (off)
      3'd0: rd_val[3:0]         = ctrl_reg;
      3'd1: rd_val[PRESC_W-1:0] = presc_reg;
      3'd2: rd_val              = count_reg;
      3'd3: rd_val              = compare_reg;
      3'd4: rd_val[1:0]         = {ovf_reg, match_reg};
      default: rd_val           = '0;
    endcase
  end

  assign cpu_rdata = sel ? rd_val : ram_rdata;

endmodule

// File: tb/tb_timer_mmio.sv
// Directed bench for timer_mmio: one task per feature, hand-computed expectations.
module tb_timer_mmio;

  localparam logic [31:0] A_CTRL  = 32'h100;
  localparam logic [31:0] A_PRESC = 32'h104;
  localparam logic [31:0] A_COUNT = 32'h108;
  localparam logic [31:0] A_CMP   = 32'h10C;
  localparam logic [31:0] A_STAT  = 32'h110;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] ram_rdata = 32'h1234_5678;
  logic        ram_we;
  logic [31:0] cpu_rdata;
  logic        irq;

  int passed = 0;
  int total  = 0;

  timer_mmio #(.BASE_ADDR(32'h0000_0100), .PRESC_W(16)) dut (
    .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .ram_rdata(ram_rdata), .ram_we(ram_we),
    .cpu_rdata(cpu_rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    @(posedge clk); #1;
    cpu_we = 1'b0;
    $display("wr  [%h] <= %h", a, d);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    cpu_we = 1'b0; cpu_addr = a;
    #1;
    d = cpu_rdata;
    $display("rd  [%h] => %h", a, d);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b0;
    cpu_we = 1'b1; cpu_addr = 32'h10; #2;
    total++; if (ram_we !== 1'b1) $display("FAIL rst_ram_we_ram got %b exp 1", ram_we); else passed++;
    total++; if (cpu_rdata !== 32'h1234_5678) $display("FAIL rst_rdata_ram got %h exp 12345678", cpu_rdata); else passed++;
    cpu_addr = 32'h108; #1;
    total++; if (ram_we !== 1'b0) $display("FAIL rst_ram_we_reg got %b exp 0", ram_we); else passed++;
    total++; if (cpu_rdata !== 32'h0) $display("FAIL rst_rdata_reg got %h exp 0", cpu_rdata); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL rst_irq got %b exp 0", irq); else passed++;
    cpu_we = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
    for (int i = 0; i < 5; i++) begin
      rd(A_CTRL + 32'(i * 4), d);
      total++; if (d !== 32'h0) $display("FAIL rst_reg%0d got %h exp 0", i, d); else passed++;
    end
    total++; if (irq !== 1'b0) $display("FAIL rst_irq_after got %b exp 0", irq); else passed++;
  endtask

  task automatic test_decode;
    logic [31:0] d;
    cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF; #1;
    total++; if (ram_we !== 1'b1) $display("FAIL dec_ram_we got %b exp 1", ram_we); else passed++;
    step(1); cpu_we = 1'b0;
    ram_rdata = 32'hCAFE_0001;
    rd(32'h10, d);
    total++; if (d !== 32'hCAFE_0001) $display("FAIL dec_ram_read got %h exp cafe0001", d); else passed++;
    cpu_we = 1'b1; cpu_addr = A_COUNT; cpu_wdata = 32'hDEAD_BEEF; #1;
    total++; if (ram_we !== 1'b0) $display("FAIL dec_ram_we_blk got %b exp 0", ram_we); else passed++;
    step(1); cpu_we = 1'b0;
    rd(A_COUNT, d);
    total++; if (d !== 32'hDEAD_BEEF) $display("FAIL dec_count got %h exp deadbeef", d); else passed++;
    rd(32'h11C, d);
    total++; if (d !== 32'h0) $display("FAIL dec_unused got %h exp 0", d); else passed++;
  endtask

  task automatic test_prescale;
    logic [31:0] d;
    wr(A_COUNT, 0); wr(A_PRESC, 3); wr(A_CMP, 5);
    wr(A_CTRL, 5);                       // edge E0; ticks at E4, E8, ...
    step(3); rd(A_COUNT, d);
    total++; if (d !== 32'd0) $display("FAIL pre_e3 got %0d exp 0", d); else passed++;
    step(1); rd(A_COUNT, d);
    total++; if (d !== 32'd1) $display("FAIL pre_e4 got %0d exp 1", d); else passed++;
    step(4); rd(A_COUNT, d);
    total++; if (d !== 32'd2) $display("FAIL pre_e8 got %0d exp 2", d); else passed++;
    step(15); rd(A_COUNT, d);
    total++; if (d !== 32'd5) $display("FAIL pre_e23 got %0d exp 5", d); else passed++;
    rd(A_STAT, d);
    total++; if (d !== 32'd0) $display("FAIL pre_stat_e23 got %h exp 0", d); else passed++;
    step(1); rd(A_COUNT, d);
    total++; if (d !== 32'd6) $display("FAIL pre_e24 got %0d exp 6", d); else passed++;
    rd(A_STAT, d);
    total++; if (d !== 32'd1) $display("FAIL pre_match got %h exp 1", d); else passed++;
    step(1);
    total++; if (irq !== 1'b1) $display("FAIL pre_irq got %b exp 1", irq); else passed++;
    wr(A_STAT, 1);
    step(1);
    total++; if (irq !== 1'b0) $display("FAIL pre_irq_clr got %b exp 0", irq); else passed++;
    rd(A_STAT, d);
    total++; if (d !== 32'd0) $display("FAIL pre_stat_clr got %h exp 0", d); else passed++;
    wr(A_CTRL, 0);
  endtask

  task automatic test_autoreload_oneshot;
    logic [31:0] d;
    wr(A_COUNT, 0); wr(A_STAT, 3); wr(A_PRESC, 0); wr(A_CMP, 2);
    wr(A_CTRL, 3);
    for (int k = 1; k <= 6; k++) begin
      step(1); rd(A_COUNT, d);
      total++; if (d !== 32'(k % 3)) $display("FAIL ar_seq%0d got %0d exp %0d", k, d, k % 3); else passed++;
    end
    wr(A_CTRL, 0);
    wr(A_COUNT, 0); wr(A_STAT, 3);
    wr(A_CTRL, 9);
    step(6); rd(A_COUNT, d);
    total++; if (d !== 32'd3) $display("FAIL os_count got %0d exp 3", d); else passed++;
    rd(A_CTRL, d);
    total++; if (d !== 32'h8) $display("FAIL os_ctrl got %h exp 8", d); else passed++;
    rd(A_STAT, d);
    total++; if (d !== 32'h1) $display("FAIL os_stat got %h exp 1", d); else passed++;
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    wr(A_CTRL, 0); wr(A_STAT, 3); wr(A_PRESC, 0); wr(A_CMP, 0);
    wr(A_COUNT, 32'hFFFF_FFFE);
    wr(A_CTRL, 1);
    step(2); rd(A_COUNT, d);
    total++; if (d !== 32'd0) $display("FAIL ovf_count got %h exp 0", d); else passed++;
    rd(A_STAT, d);
    total++; if (d !== 32'h2) $display("FAIL ovf_stat got %h exp 2", d); else passed++;
    step(1); rd(A_STAT, d);
    total++; if (d !== 32'h3) $display("FAIL ovf_match got %h exp 3", d); else passed++;
    rd(A_COUNT, d);
    total++; if (d !== 32'd1) $display("FAIL ovf_count2 got %h exp 1", d); else passed++;
  endtask

  task automatic test_collisions;
    logic [31:0] d;
    wr(A_CTRL, 0); wr(A_STAT, 3); wr(A_PRESC, 3); wr(A_COUNT, 0); wr(A_CMP, 32'h50);
    wr(A_CTRL, 1);                       // E0; ticks at E4, E8, E12, E16
    step(3);
    wr(A_COUNT, 32'h100);                // lands on tick edge E4
    rd(A_COUNT, d);
    total++; if (d !== 32'h100) $display("FAIL col_count got %h exp 100", d); else passed++;
    step(3); rd(A_COUNT, d);
    total++; if (d !== 32'h100) $display("FAIL col_hold got %h exp 100", d); else passed++;
    step(1); rd(A_COUNT, d);
    total++; if (d !== 32'h101) $display("FAIL col_next got %h exp 101", d); else passed++;
    wr(A_CMP, 32'h102);                  // E9; match happens at E16
    step(6);
    wr(A_STAT, 1);                       // W1C on E16
    rd(A_STAT, d);
    total++; if (d !== 32'h1) $display("FAIL col_w1c got %h exp 1", d); else passed++;
  endtask

  task automatic test_async_reset;
    logic [31:0] d;
    wr(A_CTRL, 5);
    step(1);
    total++; if (irq !== 1'b1) $display("FAIL ar_irq_pre got %b exp 1", irq); else passed++;
    reset = 1'b0;
    #1;
    total++; if (irq !== 1'b0) $display("FAIL ar_irq got %b exp 0", irq); else passed++;
    rd(A_COUNT, d);
    total++; if (d !== 32'h0) $display("FAIL ar_count got %h exp 0", d); else passed++;
    rd(A_STAT, d);
    total++; if (d !== 32'h0) $display("FAIL ar_stat got %h exp 0", d); else passed++;
    rd(A_CTRL, d);
    total++; if (d !== 32'h0) $display("FAIL ar_ctrl got %h exp 0", d); else passed++;
    #1 reset = 1'b1;
    rd(A_CMP, d);
    total++; if (d !== 32'h0) $display("FAIL ar_cmp got %h exp 0", d); else passed++;
    rd(A_PRESC, d);
    total++; if (d !== 32'h0) $display("FAIL ar_presc got %h exp 0", d); else passed++;
    step(2); rd(A_COUNT, d);
    total++; if (d !== 32'h0) $display("FAIL ar_idle got %h exp 0", d); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_decode();
    test_prescale();
    test_autoreload_oneshot();
    test_overflow();
    test_collisions();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
